// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the nRisc core: data port has priority over instruction fetch.
// Optional stall-cycle counter is built when MEM_ARB_STALL_CNT_EN is defined.
module mem_arbiter #(
  parameter int unsigned              ADDR_W    = 8,
  parameter int unsigned              DATA_W    = 8,
  parameter logic [ADDR_W-1:0]        DATA_BASE = 'h80,
  parameter int unsigned              TIMEOUT   = 16
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  input  logic              LerMem,
  input  logic              EscMem,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              data_req, fetch_req, busy, timeout_hit, done;
  logic [DATA_W-1:0] rd_val;

  // A requester keeps its request up during its own valid cycle; mask it so
  // the completed access is not reissued and exactly one IDLE cycle separates accesses.
  assign data_req    = (LerMem | EscMem) & ~dm_valid;
  assign fetch_req   = if_req & ~if_valid;
  assign busy        = (state != IDLE);
  assign timeout_hit = busy & ~mem_ready & (tmo_cnt == TMO_LAST);
  assign done        = busy & (mem_ready | timeout_hit);
  assign rd_val      = mem_ready ? mem_rdata : '1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (data_req)       state_nx = EscMem ? DWRITE : DREAD;
        else if (fetch_req) state_nx = FETCH;
      end
      default: begin
        if (done) state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      FETCH: begin
        mem_addr = if_addr;
        mem_re   = 1'b1;
      end
      DREAD: begin
        mem_addr = dm_addr + DATA_BASE;
        mem_re   = 1'b1;
      end
      DWRITE: begin
        mem_addr  = dm_addr + DATA_BASE;
        mem_wdata = dm_wdata;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      if_data  <= '0;
      if_valid <= 1'b0;
      dm_rdata <= '0;
      dm_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      if_valid <= done & (state == FETCH);
      dm_valid <= done & ((state == DREAD) | (state == DWRITE));
      if (state == IDLE) tmo_cnt <= '0;
      else               tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (done && state == FETCH) if_data  <= rd_val;
      if (done && state == DREAD) dm_rdata <= rd_val;
      if (timeout_hit || (state == IDLE && data_req && LerMem && EscMem)) err <= 1'b1;
    end
  end

  assign stall = reset & ((if_req & ~if_valid) | ((LerMem | EscMem) & ~dm_valid));

`ifdef MEM_ARB_STALL_CNT_EN
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset)                       stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked each cycle against a transaction-window model of the arbiter.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic       Clock = 1'b0;
  logic       reset = 1'b0;
  logic       if_req = 1'b0, LerMem = 1'b0, EscMem = 1'b0, mem_ready = 1'b0;
  logic [7:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [7:0] if_data, dm_rdata, mem_addr, mem_wdata;
  logic       if_valid, dm_valid, mem_re, mem_we, stall, err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .DATA_BASE(8'h80), .TIMEOUT(TO)) dut (
    .Clock(Clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .LerMem(LerMem), .EscMem(EscMem), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // model state: one outstanding transaction described by its grant cycle and length
  bit         chk_en = 1'b0;
  int         cyc, t_start, t_len, t_d, t_kind;
  bit         act, coll_pend;
  logic [7:0] t_rdata, m_if_data, m_dm_rdata;
  logic       m_err;
  int         stall_acc;
  bit         f_pend, f_drop, f_granted, d_pend, d_drop, d_granted, d_rd, d_wr;
  logic       exp_mem_re, exp_mem_we, exp_if_valid, exp_dm_valid, exp_stall, exp_err;
  logic [7:0] exp_mem_addr, exp_mem_wdata, exp_if_data, exp_dm_rdata;
  logic [15:0] exp_stall_cnt;

  task automatic model_init();
    cyc = 0; act = 0; coll_pend = 0; t_start = 0; t_len = 0; t_d = 0; t_kind = 0;
    m_if_data = '0; m_dm_rdata = '0; m_err = 1'b0; stall_acc = 0;
    f_pend = 0; f_drop = 0; f_granted = 0; d_pend = 0; d_drop = 0; d_granted = 0;
    d_rd = 0; d_wr = 0;
    exp_mem_re = 0; exp_mem_we = 0; exp_if_valid = 0; exp_dm_valid = 0; exp_stall = 0;
    exp_err = 0; exp_mem_addr = '0; exp_mem_wdata = '0; exp_if_data = '0;
    exp_dm_rdata = '0; exp_stall_cnt = '0;
  endtask

  task automatic clear_inputs();
    if_req = 0; LerMem = 0; EscMem = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    #2 reset = 1'b0;
    clear_inputs();
    tick();
    if_req = 1; LerMem = 1;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_dm_valid", dm_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    check("rst_if_data", if_data, 8'h00);
    clear_inputs();
    tick();
    reset = 1'b1;
    model_init();
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      check("mem_re", mem_re, exp_mem_re);
      check("mem_we", mem_we, exp_mem_we);
      check("mem_addr", mem_addr, exp_mem_addr);
      check("mem_wdata", mem_wdata, exp_mem_wdata);
      check("if_valid", if_valid, exp_if_valid);
      check("dm_valid", dm_valid, exp_dm_valid);
      check("if_data", if_data, exp_if_data);
      check("dm_rdata", dm_rdata, exp_dm_rdata);
      check("err", err, exp_err);
      check("stall", stall, exp_stall);
      check("stall_cnt", stall_cnt, exp_stall_cnt);
    end
  end

  task automatic step();
    logic       busy, vnow, dreq, freq, pv_if, pv_dm;
    logic [7:0] res;
    int         r;
    tick();
    cyc++;
    pv_if = exp_if_valid;
    pv_dm = exp_dm_valid;

    if (f_pend && pv_if) begin f_pend = 0; f_drop = 0; f_granted = 0; end
    if (!f_pend && $urandom_range(0, 2) == 0) begin f_pend = 1; if_addr = 8'($urandom); end
    else if (!f_pend) if_addr = 8'($urandom);
    if (f_pend && f_granted && !f_drop && $urandom_range(0, 7) == 0) f_drop = 1;
    if_req = f_pend && !f_drop;

    if (d_pend && pv_dm) begin d_pend = 0; d_drop = 0; d_granted = 0; end
    if (!d_pend && $urandom_range(0, 2) == 0) begin
      d_pend = 1;
      r = int'($urandom_range(0, 9));
      d_rd = (r <= 4);
      d_wr = (r == 0) || (r >= 5);
      dm_addr = 8'($urandom);
      dm_wdata = 8'($urandom);
    end else if (!d_pend) begin
      dm_addr = 8'($urandom);
      dm_wdata = 8'($urandom);
    end
    if (d_pend && d_granted && !d_drop && $urandom_range(0, 7) == 0) d_drop = 1;
    LerMem = d_pend && !d_drop && d_rd;
    EscMem = d_pend && !d_drop && d_wr;

    busy = act && (cyc > t_start) && (cyc <= t_start + t_len);
    if (busy) begin
      mem_ready = (cyc == t_start + t_d);
      mem_rdata = mem_ready ? t_rdata : 8'($urandom);
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = 8'($urandom);
    end

    if (coll_pend) begin m_err = 1; coll_pend = 0; end
    vnow = act && (cyc == t_start + t_len + 1);
    if (vnow) begin
      res = (t_d <= TO) ? t_rdata : 8'hFF;
      if (t_kind == 0) m_if_data = res;
      if (t_kind == 1) m_dm_rdata = res;
      if (t_d > TO) m_err = 1;
      act = 0;
    end

    exp_mem_re    = busy && (t_kind != 2);
    exp_mem_we    = busy && (t_kind == 2);
    exp_mem_addr  = !busy ? 8'h00 : (t_kind == 0) ? if_addr : 8'(dm_addr + 8'h80);
    exp_mem_wdata = (busy && t_kind == 2) ? dm_wdata : 8'h00;
    exp_if_valid  = vnow && (t_kind == 0);
    exp_dm_valid  = vnow && (t_kind != 0);
    exp_if_data   = m_if_data;
    exp_dm_rdata  = m_dm_rdata;
    exp_err       = m_err;
    exp_stall     = (if_req && !exp_if_valid) || ((LerMem || EscMem) && !exp_dm_valid);
`ifdef MEM_ARB_STALL_CNT_EN
    exp_stall_cnt = (stall_acc > 65535) ? 16'hFFFF : 16'(stall_acc);
    if (exp_stall) stall_acc++;
`else
    exp_stall_cnt = 16'h0;
`endif

    if (!act) begin
      dreq = (LerMem || EscMem) && !exp_dm_valid;
      freq = if_req && !exp_if_valid;
      if (dreq || freq) begin
        act = 1;
        t_start = cyc;
        if (dreq) begin
          t_kind = EscMem ? 2 : 1;
          coll_pend = LerMem && EscMem;
          d_granted = 1;
        end else begin
          t_kind = 0;
          f_granted = 1;
        end
        r = int'($urandom_range(0, 9));
        if (r < 6)      t_d = int'($urandom_range(1, 4));
        else if (r < 8) t_d = TO;
        else            t_d = TO + 1 + int'($urandom_range(0, 3));
        t_len = (t_d <= TO) ? t_d : TO;
        t_rdata = 8'($urandom);
      end
    end
    chk_en = 1;
  endtask

  initial begin
    model_init();
    do_reset();

    // fetch only, single-cycle memory
    if_req = 1; if_addr = 8'h05;
    #1 check("t1_stall_c0", stall, 1'b1);
    check("t1_re_c0", mem_re, 1'b0);
    tick(); mem_ready = 1; mem_rdata = 8'hA3;
    #1 check("t1_re_c1", mem_re, 1'b1);
    check("t1_addr_c1", mem_addr, 8'h05);
    tick(); mem_ready = 0;
    #1 check("t1_if_valid", if_valid, 1'b1);
    check("t1_if_data", if_data, 8'hA3);
    check("t1_re_c2", mem_re, 1'b0);
    check("t1_stall_c2", stall, 1'b0);
    tick(); if_req = 0;
    #1 check("t1_if_valid_off", if_valid, 1'b0);
    check("t1_if_data_held", if_data, 8'hA3);

    // data read and fetch collide: data first, one IDLE cycle, then fetch
    if_req = 1; if_addr = 8'h11; LerMem = 1; dm_addr = 8'h02;
    tick(); mem_ready = 1; mem_rdata = 8'h5A;
    #1 check("t2_addr_c1", mem_addr, 8'h82);
    check("t2_re_c1", mem_re, 1'b1);
    check("t2_stall_c1", stall, 1'b1);
    tick(); mem_ready = 0;
    #1 check("t2_dm_valid", dm_valid, 1'b1);
    check("t2_dm_rdata", dm_rdata, 8'h5A);
    check("t2_idle_re", mem_re, 1'b0);
    check("t2_stall_c2", stall, 1'b1);
    tick(); LerMem = 0; mem_ready = 1; mem_rdata = 8'h77;
    #1 check("t2_fetch_re", mem_re, 1'b1);
    check("t2_fetch_addr", mem_addr, 8'h11);
    check("t2_stall_c3", stall, 1'b1);
    tick(); mem_ready = 0;
    #1 check("t2_if_valid", if_valid, 1'b1);
    check("t2_if_data", if_data, 8'h77);
    check("t2_stall_c4", stall, 1'b0);
    tick(); if_req = 0;

    // write with address wrap, three strobe cycles
    EscMem = 1; dm_addr = 8'h90; dm_wdata = 8'h3C;
    for (int i = 1; i <= 3; i++) begin
      tick(); mem_ready = (i == 3);
      #1 check("t3_we", mem_we, 1'b1);
      check("t3_addr", mem_addr, 8'h10);
      check("t3_wdata", mem_wdata, 8'h3C);
      check("t3_re", mem_re, 1'b0);
    end
    tick(); mem_ready = 0;
    #1 check("t3_dm_valid", dm_valid, 1'b1);
    check("t3_we_off", mem_we, 1'b0);
    check("t3_err", err, 1'b0);
    tick(); EscMem = 0;

    // read timeout
    LerMem = 1; dm_addr = 8'h00;
    for (int i = 1; i <= TO; i++) begin
      tick();
      #1 check("t4_re", mem_re, 1'b1);
      check("t4_no_valid", dm_valid, 1'b0);
    end
    tick();
    #1 check("t4_dm_valid", dm_valid, 1'b1);
    check("t4_dm_rdata", dm_rdata, 8'hFF);
    check("t4_err", err, 1'b1);
    check("t4_re_off", mem_re, 1'b0);
    tick(); LerMem = 0;
    #1 check("t4_err_sticky", err, 1'b1);
    do_reset();

    // read+write together: write wins, err raised
    LerMem = 1; EscMem = 1; dm_addr = 8'h01; dm_wdata = 8'h99;
    tick(); mem_ready = 1;
    #1 check("tc_we", mem_we, 1'b1);
    check("tc_re", mem_re, 1'b0);
    check("tc_addr", mem_addr, 8'h81);
    check("tc_err", err, 1'b1);
    tick(); mem_ready = 0;
    #1 check("tc_dm_valid", dm_valid, 1'b1);
    tick(); LerMem = 0; EscMem = 0;
    do_reset();

    // reset during a write
    EscMem = 1; dm_addr = 8'h20; dm_wdata = 8'h44;
    tick();
    #1 check("t5_we_before", mem_we, 1'b1);
    #1 reset = 0;
    #1 check("t5_we_async", mem_we, 1'b0);
    check("t5_stall_rst", stall, 1'b0);
    EscMem = 0;
    tick(); mem_ready = 1;
    #1 check("t5_no_valid_rst", dm_valid, 1'b0);
    tick(); mem_ready = 0; reset = 1;
    if_req = 1; if_addr = 8'h42;
    tick(); mem_ready = 1; mem_rdata = 8'hC7;
    #1 check("t5_fetch_re", mem_re, 1'b1);
    check("t5_fetch_addr", mem_addr, 8'h42);
    check("t5_no_dm_valid", dm_valid, 1'b0);
    tick(); mem_ready = 0;
    #1 check("t5_if_valid", if_valid, 1'b1);
    check("t5_if_data", if_data, 8'hC7);
    check("t5_no_dm_valid2", dm_valid, 1'b0);
    tick(); if_req = 0;

`ifdef MEM_ARB_STALL_CNT_EN
    do_reset();
    LerMem = 1;
    repeat (5) tick();
    #1 check("t6_stall_cnt5", stall_cnt, 16'd5);
    repeat (70000) tick();
    #1 check("t6_stall_cnt_sat", stall_cnt, 16'hFFFF);
    LerMem = 0;
`endif

    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      repeat (600) step();
      chk_en = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
